hilo_muldiv: RTL and testbench

// - Multiply/divide unit and HI/LO register pair for the multicycle MIPS core; sits downstream of control.
// - Consumes control's Hi_enable/Lo_enable and the funct field; serves MULT/MULTU/DIV/DIVU/MTHI/MTLO and the MFHI/MFLO reads.
// - Multiply is single-cycle. Divide is iterative restoring; busy stalls the state sequencer in WRITEBACK.

---
 rtl/mips_muldiv_pkg.sv | 34 +++
 rtl/div_iter.sv | 65 ++++++
 rtl/hilo_muldiv.sv | 166 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: funct codes, FSM states
// and small funct decode helpers.
package mips_muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL     = 3'd1,
    DIV_RUN = 3'd2,
    DIV_FIX = 3'd3,
    DONE    = 3'd4
  } muldiv_state_t;

  function automatic logic is_mul(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
  endfunction

  function automatic logic is_div(input logic [5:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per clock after load.
// done is high during the cycle of the final iteration; results are valid after that edge.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [CW-1:0]    cnt_r;
  logic             run_r;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] rem_nx_s, quo_nx_s;

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
  always_comb begin
    trial_s  = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};
    rem_nx_s = rem_r;
    quo_nx_s = quo_r;
    if (!trial_s[WIDTH]) begin
      rem_nx_s = trial_s[WIDTH-1:0];
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration state; quo_r doubles as the dividend shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r <= {WIDTH{1'b0}};
      quo_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b0;
    end else if (load) begin
      rem_r <= {WIDTH{1'b0}};
      quo_r <= dividend;
      dvs_r <= divisor;
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b1;
    end else if (run_r) begin
      rem_r <= rem_nx_s;
      quo_r <= quo_nx_s;
      cnt_r <= cnt_r + CW'(1);
      run_r <= (cnt_r != CNT_LAST);
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
  assign done      = run_r && (cnt_r == CNT_LAST);

endmodule

// File: rtl/hilo_muldiv.sv
// MIPS multiply/divide unit with the HI/LO register pair: single-cycle multiply,
// iterative signed/unsigned divide, and enable-gated commit into HI/LO.
module hilo_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_enable,
  input  logic             lo_enable,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             result_valid
);

  muldiv_state_t      state_r, state_s;
  logic [5:0]         funct_r;
  logic [WIDTH-1:0]   op_a_r, op_b_r, pend_hi_r, pend_lo_r, hi_r, lo_r;
  logic               busy_r, busy_s, result_valid_r, neg_q_r, neg_r_r;
  logic               start_ok_s, commit_s, sgn_s, div_done_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_s, rem_s, fix_q_s, fix_r_s;
  logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s;

  always_comb begin
    start_ok_s = start && !busy_r;
    commit_s   = !busy_r && (hi_enable || lo_enable);
  end

  // Divider sees magnitudes; the signs are re-applied in DIV_FIX.
  always_comb begin
    sgn_s   = is_signed_op(funct);
    mag_a_s = (sgn_s && op_a[WIDTH-1]) ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
    mag_b_s = (sgn_s && op_b[WIDTH-1]) ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
    fix_q_s = neg_q_r ? (~quo_s + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_s;
    fix_r_s = neg_r_r ? (~rem_s + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_s;
  end

  always_comb begin
    if (funct_r == FUNCT_MULT) begin
      a_ext_s = {{WIDTH{op_a_r[WIDTH-1]}}, op_a_r};
      b_ext_s = {{WIDTH{op_b_r[WIDTH-1]}}, op_b_r};
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, op_a_r};
      b_ext_s = {{WIDTH{1'b0}}, op_b_r};
    end
    prod_s = a_ext_s * b_ext_s;
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok_s && is_div(funct)),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .quotient  (quo_s),
    .remainder (rem_s),
    .done      (div_done_s)
  );

  // Next state; a fresh start out of IDLE/DONE takes priority over the commit-to-IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_ok_s && is_mul(funct)) begin
          state_s = MUL;
        end else if (start_ok_s && is_div(funct)) begin
          state_s = DIV_RUN;
        end else if (commit_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      MUL:     state_s = DONE;
      DIV_RUN: state_s = div_done_s ? DIV_FIX : DIV_RUN;
      DIV_FIX: state_s = DONE;
      default: state_s = IDLE;
    endcase
    busy_s = (state_s == MUL) || (state_s == DIV_RUN) || (state_s == DIV_FIX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      busy_r         <= busy_s;
      result_valid_r <= (state_s == DONE);
    end
  end

  // Operand latch; ignored while busy so an in-flight divide keeps its operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct_r <= 6'h00;
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (start_ok_s) begin
      funct_r <= funct;
      op_a_r  <= op_a;
      op_b_r  <= op_b;
      neg_q_r <= sgn_s && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_r_r <= sgn_s && op_a[WIDTH-1];
    end
  end

  // Pending result; signed overflow falls out of the magnitude path without a special case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_hi_r <= {WIDTH{1'b0}};
      pend_lo_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        MUL: begin
          pend_hi_r <= prod_s[2*WIDTH-1:WIDTH];
          pend_lo_r <= prod_s[WIDTH-1:0];
        end
        DIV_FIX: begin
          if (op_b_r == {WIDTH{1'b0}}) begin
            pend_hi_r <= op_a_r;
            pend_lo_r <= {WIDTH{1'b1}};
          end else begin
            pend_hi_r <= fix_r_s;
            pend_lo_r <= fix_q_s;
          end
        end
        default: begin
          pend_hi_r <= pend_hi_r;
          pend_lo_r <= pend_lo_r;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (commit_s) begin
      if (is_mul(funct_r) || is_div(funct_r)) begin
        if (hi_enable) hi_r <= pend_hi_r;
        if (lo_enable) lo_r <= pend_lo_r;
      end else begin
        if (hi_enable && (funct_r == FUNCT_MTHI)) hi_r <= op_a_r;
        if (lo_enable && (funct_r == FUNCT_MTLO)) lo_r <= op_a_r;
      end
    end
  end

  assign hi           = hi_r;
  assign lo           = lo_r;
  assign busy         = busy_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply/divide results, latency, commit gating,
// start/commit collision and asynchronous reset during a divide.
module tb_hilo_muldiv;

  localparam int W = 32;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A,
                         F_DIVU = 6'h1B, F_MTHI = 6'h11;

  logic         clk = 1'b0;
  logic         reset, start, hi_enable, lo_enable;
  logic [5:0]   funct;
  logic [W-1:0] op_a, op_b, hi, lo;
  logic         busy, result_valid;
  int           n_chk = 0;
  int           n_bad = 0;
  int           ncyc;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .op_a(op_a), .op_b(op_b),
    .hi_enable(hi_enable), .lo_enable(lo_enable), .hi(hi), .lo(lo),
    .busy(busy), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge; returns at the falling edge after that edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic commit(input logic he, input logic le);
    hi_enable = he; lo_enable = le;
    @(negedge clk);
    hi_enable = 1'b0; lo_enable = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(f, a, b);
    check_eq({tag, "_busy"}, busy, 32'd1);
    wait_idle(n);
    check_eq({tag, "_lat"}, n, exp_n);
    check_eq({tag, "_rv"}, result_valid, 32'd1);
    commit(1'b1, 1'b1);
    check_eq({tag, "_hi"}, hi, exp_hi);
    check_eq({tag, "_lo"}, lo, exp_lo);
    check_eq({tag, "_rv_clr"}, result_valid, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_enable = 1'b0; lo_enable = 1'b0;
    funct = 6'h00; op_a = 32'h0; op_b = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_hi", hi, 32'h0);
    check_eq("rst_lo", lo, 32'h0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_rv", result_valid, 32'd0);
    reset = 1'b0;

    run_op("mult",   F_MULT,  32'hFFFFFFFE, 32'h3,        1,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu",  F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  32'hFFFFFFFE, 32'h00000001);
    run_op("div",    F_DIV,   32'hFFFFFFF9, 32'h2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_nb", F_DIV,   32'h7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu0",  F_DIVU,  32'h1234,     32'h0,        33, 32'h00001234, 32'hFFFFFFFF);
    run_op("div_ov", F_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);

    // Enables and a new start during a divide must both be ignored.
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    commit(1'b1, 1'b1);
    check_eq("gate_hi", hi, 32'h0);
    check_eq("gate_lo", lo, 32'h80000000);
    issue(F_MULTU, 32'd5, 32'd5);
    check_eq("gate_busy", busy, 32'd1);
    wait_idle(ncyc);
    check_eq("gate_rv", result_valid, 32'd1);
    commit(1'b1, 1'b1);
    check_eq("gate_q", lo, 32'hE);
    check_eq("gate_r", hi, 32'h2);

    issue(F_MTHI, 32'hCAFEF00D, 32'h0);
    check_eq("mthi_busy", busy, 32'd0);
    commit(1'b1, 1'b0);
    check_eq("mthi_hi", hi, 32'hCAFEF00D);
    check_eq("mthi_lo", lo, 32'hE);

    // Start and commit on the same edge: commit sees the old pending product.
    issue(F_MULTU, 32'd2, 32'd3);
    wait_idle(ncyc);
    funct = F_MULTU; op_a = 32'd4; op_b = 32'd5; start = 1'b1;
    hi_enable = 1'b1; lo_enable = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_enable = 1'b0; lo_enable = 1'b0;
    check_eq("coll_hi", hi, 32'h0);
    check_eq("coll_lo", lo, 32'h6);
    check_eq("coll_busy", busy, 32'd1);
    wait_idle(ncyc);
    commit(1'b1, 1'b1);
    check_eq("coll_new_lo", lo, 32'h14);

    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check_eq("pre_rst_busy", busy, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", busy, 32'd0);
    check_eq("arst_rv", result_valid, 32'd0);
    check_eq("arst_hi", hi, 32'h0);
    check_eq("arst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_rst", F_MULTU, 32'h00010001, 32'h00010000, 1, 32'h00000001, 32'h00010000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
